// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin arbiter that drives a shared mux select and hands the captured data downstream.
// Optional feature: define MUX_SCHED_PRIO0_EN to give requester 0 strict priority over the round-robin.
module mux_rr_scheduler #(
  parameter int NREQ = 31,
  parameter int DW   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [4:0]      mux_sel,
  input  logic [DW-1:0]   mux_out,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  // state   | meaning
  // IDLE    | waiting for any req; arbitrates and grants on the edge
  // CAPTURE | mux_sel has settled for a cycle; mux_out is registered
  // HOLD    | out_valid high until downstream accepts
  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [4:0]      sel_q, sel_d;
  logic [4:0]      ptr_q, ptr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic [4:0]      winner;
  logic            found;
  logic [5:0]      idx;

  // Search upward from ptr+1 with wrap; ptr+off never exceeds 2*NREQ, so one subtraction folds it.
  always_comb begin : rr_search
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = {1'b0, ptr_q} + 6'(off);
      if (idx >= 6'(NREQ)) idx = idx - 6'(NREQ);
      if (!found && req[idx[4:0]]) begin
        found  = 1'b1;
        winner = idx[4:0];
      end
    end
`ifdef MUX_SCHED_PRIO0_EN
    if (req[0]) begin
      found  = 1'b1;
      winner = '0;
    end
`endif
  end

  always_comb begin : next_state
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          sel_d         = winner;
          gnt_d[winner] = 1'b1;
          state_d       = CAPTURE;
        end
      end
      CAPTURE: begin
        data_d  = mux_out;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          gnt_d   = '0;
          state_d = IDLE;
`ifdef MUX_SCHED_PRIO0_EN
          // Priority grants to 0 leave the rotation among 1..NREQ-1 untouched.
          if (sel_q != 5'd0) ptr_d = sel_q;
`else
          ptr_d = sel_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= 5'(NREQ - 1);
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign mux_sel   = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb_mux_rr_scheduler: scoreboard bench for mux_rr_scheduler with a behavioural mux and arbitration model.
// Builds with or without MUX_SCHED_PRIO0_EN; expected grant sequences follow the macro.
module tb_mux_rr_scheduler;
  localparam int NREQ = 31;
  localparam int DW   = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [4:0]      mux_sel;
  logic [DW-1:0]   mux_out;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  logic [DW-1:0] mux_in [32];
  assign mux_out = mux_in[mux_sel];

  always #5 clk = ~clk;

  mux_rr_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .mux_sel(mux_sel),
    .mux_out(mux_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  typedef struct {int idx; logic [DW-1:0] data;} exp_t;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_ptr  = NREQ - 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
`ifdef MUX_SCHED_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int off = 1; off <= NREQ; off++) begin
      int i;
      i = (p + off) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = NREQ - 1;
    sb.delete();
  endtask

  // Starts with the DUT idle at a negedge; ends at the negedge after the handshake.
  task automatic run_txn(input int stall, output int got, output int lat_g, output int lat_v);
    exp_t e;
    int   w;
    w = model_pick(req, m_ptr);
    got = -1; lat_g = 0; lat_v = 0;
    if (w < 0) begin
      check("no_request", 0, 1);
      return;
    end
    sb.push_back('{w, mux_in[w]});
    out_ready = (stall == 0);
    while (gnt == '0 && lat_g < 16) begin @(negedge clk); lat_g++; end
    check("gnt_seen", {31'd0, gnt != '0}, 1);
    got = int'(mux_sel);
    check("mux_sel", {27'd0, mux_sel}, w);
    check("sel_range", {31'd0, mux_sel < 5'(NREQ)}, 1);
    check("gnt_onehot", {1'b0, gnt}, 32'(1) << w);
    check("busy_active", {31'd0, busy}, 1);
    while (!out_valid && lat_v < 16) begin @(negedge clk); lat_v++; end
    e = sb.pop_front();
    check("out_valid", {31'd0, out_valid}, 1);
    check("out_data", {30'd0, out_data}, {30'd0, e.data});
    for (int i = 0; i < stall; i++) begin
      mux_in[w] = ~mux_in[w];
      req = req ^ 31'h0000_5555;
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 1);
      check("stall_data", {30'd0, out_data}, {30'd0, e.data});
      check("stall_gnt", {1'b0, gnt}, 32'(1) << e.idx);
      check("stall_sel", {27'd0, mux_sel}, e.idx);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("hs_valid_low", {31'd0, out_valid}, 0);
    check("hs_gnt_low", {1'b0, gnt}, 0);
    check("hs_idle", {31'd0, busy}, 0);
`ifdef MUX_SCHED_PRIO0_EN
    if (w != 0) m_ptr = w;
`else
    m_ptr = w;
`endif
  endtask

  int got, lg, lv, n;
  int rr_exp [5] = '{3, 13, 30, 3, 13};
`ifdef MUX_SCHED_PRIO0_EN
  int pr_exp [3] = '{0, 0, 0};
  int dr_exp [3] = '{7, 9, 7};
`else
  int pr_exp [4] = '{0, 7, 9, 0};
`endif

  initial begin
    for (int i = 0; i < 32; i++) mux_in[i] = 2'(i + 1);
    mux_in[12] = 2'b10;
    out_ready = 1'b1;
    reset = 1'b1;
    req = '1;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", {1'b0, gnt}, 0);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_sel", {27'd0, mux_sel}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_data", {30'd0, out_data}, 0);
    reset = 1'b0;
    run_txn(0, got, lg, lv);
    check("first_grant", got, 0);

    // single request latency
    req = 31'(1) << 12;
    run_txn(0, got, lg, lv);
    req = '0;
    check("single_idx", got, 12);
    check("lat_gnt", lg, 1);
    check("lat_valid", lv, 1);

    // round-robin with wrap
    do_reset();
    req = (31'(1) << 3) | (31'(1) << 13) | (31'(1) << 30);
    for (int i = 0; i < 5; i++) begin
      run_txn(0, got, lg, lv);
      check("rr_order", got, rr_exp[i]);
    end
    req = '0;

    // backpressure
    req = 31'(1) << 5;
    run_txn(6, got, lg, lv);
    check("bp_idx", got, 5);
    req = '0;

    // reset mid-transaction
    req = 31'(1) << 9;
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 16) begin @(negedge clk); n++; end
    check("mid_valid_seen", {31'd0, out_valid}, 1);
    reset = 1'b1;
    req = (31'(1) << 3) | (31'(1) << 13);
    @(negedge clk);
    check("mid_gnt", {1'b0, gnt}, 0);
    check("mid_valid", {31'd0, out_valid}, 0);
    check("mid_sel", {27'd0, mux_sel}, 0);
    check("mid_busy", {31'd0, busy}, 0);
    check("mid_data", {30'd0, out_data}, 0);
    reset = 1'b0;
    m_ptr = NREQ - 1;
    sb.delete();
    run_txn(0, got, lg, lv);
    check("mid_next", got, 3);
    req = '0;

    // priority / plain round-robin on {0,7,9}
    do_reset();
    req = 31'h0000_0281;
    foreach (pr_exp[i]) begin
      run_txn(0, got, lg, lv);
      check("prio_seq", got, pr_exp[i]);
    end
`ifdef MUX_SCHED_PRIO0_EN
    req[0] = 1'b0;
    foreach (dr_exp[i]) begin
      run_txn(0, got, lg, lv);
      check("prio_drop_seq", got, dr_exp[i]);
    end
`endif
    req = '0;
    @(negedge clk);
    check("end_idle", {31'd0, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
